// File: rtl/digest_collector_pkg.sv
// Shared definitions for the digest collector: FSM encoding and digest geometry.
package digest_collector_pkg;

  localparam int DIGEST_WORDS = 8;
  localparam int DIGEST_BYTES = 32;
  localparam int DIGEST_WIDTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } digest_state_e;

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_COLLECT = ST_COLLECT;
  localparam logic [1:0] S_SEND    = ST_SEND;
  localparam logic [1:0] S_DONE    = ST_DONE;

endpackage

// File: rtl/digest_byte_mux.sv
// Big-endian byte serializer for the assembled digest with a valid/ready
// handshake; the byte index advances only on an accepted transfer.
module digest_byte_mux
  import digest_collector_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    ready_i,
  input  logic [DIGEST_WIDTH-1:0] digest_i,
  output logic [7:0]              byte_o,
  output logic                    valid_o,
  output logic                    last_accept_o
);

  logic [4:0] byte_cnt_q, byte_cnt_d;
  logic       accept;
  logic [7:0] mux_byte;

  assign valid_o       = en_i;
  assign accept        = en_i & ready_i;
  assign last_accept_o = accept && (byte_cnt_q == 5'(DIGEST_BYTES - 1));
  assign byte_o        = en_i ? mux_byte : 8'h00;

  always_comb begin
    mux_byte = 8'h00;
    for (int i = 0; i < DIGEST_BYTES; i++) begin
      if (byte_cnt_q == 5'(i)) mux_byte = digest_i[DIGEST_WIDTH-1-8*i -: 8];
    end
  end

  // Index returns to zero whenever SEND is left, so every transfer starts at byte 0.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (clear_i || !en_i) byte_cnt_d = 5'd0;
    else if (accept)      byte_cnt_d = byte_cnt_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byte_cnt_q <= 5'd0;
    else        byte_cnt_q <= byte_cnt_d;
  end

endmodule

// File: rtl/digest_collector.sv
// Collects eight final hash words into a 256-bit digest and streams it out
// bytewise. Optional comparator against an expected digest: DIGEST_COMPARE_EN.
//
// state   | meaning
// IDLE    | waiting for word 0
// COLLECT | storing words 1..7
// SEND    | streaming 32 digest bytes
// DONE    | one-cycle completion pulse
module digest_collector
  import digest_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_in,
  input  logic                    hash_valid_in,
  input  logic [DATA_WIDTH-1:0]   hash_data_in,
  input  logic                    byte_ready_in,
`ifdef DIGEST_COMPARE_EN
  input  logic [DIGEST_WIDTH-1:0] expected_digest_in,
  output logic                    match_out,
`endif
  output logic [7:0]              byte_out,
  output logic                    byte_valid_out,
  output logic [DIGEST_WIDTH-1:0] digest_out,
  output logic                    digest_done_out,
  output logic                    busy_out,
  output logic                    overrun_out
);

  logic [1:0]              state_q, state_d;
  logic [2:0]              word_cnt_q, word_cnt_d;
  logic [DIGEST_WIDTH-1:0] digest_q, digest_d;
  logic                    overrun_q, overrun_d;
  logic                    last_accept;
`ifdef DIGEST_COMPARE_EN
  logic                    match_q, match_d;
  assign match_out = match_q;
`endif

  assign digest_out      = digest_q;
  assign digest_done_out = (state_q == S_DONE);
  assign busy_out        = (state_q != S_IDLE);
  assign overrun_out     = overrun_q;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    digest_d   = digest_q;
    overrun_d  = overrun_q;
`ifdef DIGEST_COMPARE_EN
    match_d    = match_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (hash_valid_in) begin
          digest_d[DIGEST_WIDTH-1 -: 32] = hash_data_in;
          word_cnt_d = 3'd1;
          state_d    = S_COLLECT;
`ifdef DIGEST_COMPARE_EN
          match_d    = 1'b0;
`endif
        end
      end
      S_COLLECT: begin
        if (hash_valid_in) begin
          for (int i = 1; i < DIGEST_WORDS; i++) begin
            if (word_cnt_q == 3'(i)) digest_d[DIGEST_WIDTH-1-32*i -: 32] = hash_data_in;
          end
          word_cnt_d = word_cnt_q + 3'd1;
          if (word_cnt_q == 3'(DIGEST_WORDS - 1)) state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (hash_valid_in) overrun_d = 1'b1;
        if (last_accept)   state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef DIGEST_COMPARE_EN
        match_d = (digest_q == expected_digest_in);
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any same-cycle capture; results already produced survive.
    if (clear_in) begin
      state_d    = S_IDLE;
      word_cnt_d = 3'd0;
      digest_d   = digest_q;
      overrun_d  = overrun_q;
`ifdef DIGEST_COMPARE_EN
      match_d    = match_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= 3'd0;
      digest_q   <= '0;
      overrun_q  <= 1'b0;
`ifdef DIGEST_COMPARE_EN
      match_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      digest_q   <= digest_d;
      overrun_q  <= overrun_d;
`ifdef DIGEST_COMPARE_EN
      match_q    <= match_d;
`endif
    end
  end

  digest_byte_mux u_byte_mux (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (state_q == S_SEND),
    .clear_i       (clear_in),
    .ready_i       (byte_ready_in),
    .digest_i      (digest_q),
    .byte_o        (byte_out),
    .valid_o       (byte_valid_out),
    .last_accept_o (last_accept)
  );

endmodule

// File: doc/digest_collector.md
DIGEST_COLLECTOR -- requirements
Module: digest_collector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the hash word width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port clear_in, input, 1 bit: synchronous abort and return to IDLE.
REQ-005 The block SHALL have port hash_valid_in, input, 1 bit: hash_data_in carries a final hash word this cycle.
REQ-006 The block SHALL have port hash_data_in, input, DATA_WIDTH bits: final hash word, H0 first, H7 last.
REQ-007 The block SHALL have port byte_ready_in, input, 1 bit: downstream byte sink (UART TX) accepts this cycle.
REQ-008 The block SHALL have port byte_out, output, 8 bits: serialized digest byte.
REQ-009 The block SHALL have port byte_valid_out, output, 1 bit: byte_out is valid.
REQ-010 The block SHALL have port digest_out, output, 256 bits: assembled digest, word 0 in bits [255:224].
REQ-011 The block SHALL have port digest_done_out, output, 1 bit: one-cycle pulse after the last byte is accepted.
REQ-012 The block SHALL have port busy_out, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port overrun_out, output, 1 bit: sticky flag for a hash word received while in SEND.

Function
REQ-014 The FSM SHALL have the states IDLE, COLLECT, SEND and DONE, each registered.
REQ-015 In IDLE, hash_valid_in SHALL store the word into slot 0, set word_cnt to 1 and move to COLLECT.
REQ-016 In COLLECT, each hash_valid_in SHALL store the word into slot word_cnt and increment word_cnt; cycles without valid SHALL hold state.
REQ-017 When the word in slot 7 is stored, the FSM SHALL move to SEND with byte_cnt=0 on the next cycle.
REQ-018 In SEND, byte_valid_out SHALL be 1, and byte_out SHALL be digest byte byte_cnt, big-endian: byte 0 = digest_out[255:248].
REQ-019 byte_cnt SHALL advance only when byte_valid_out and byte_ready_in are both high; byte_out SHALL stay stable while ready is low.
REQ-020 Acceptance of byte 31 SHALL move the FSM to DONE; DONE SHALL pulse digest_done_out for exactly one cycle and then go to IDLE.
REQ-021 hash_valid_in during SEND SHALL be ignored for data and SHALL set overrun_out; in DONE it SHALL be ignored without a flag.
REQ-022 digest_out SHALL hold its last assembled value until slot 0 is next overwritten.
REQ-023 clear_in SHALL force IDLE and zero word_cnt and byte_cnt; it SHALL take priority over simultaneous hash_valid_in; digest_out and overrun_out SHALL be kept.
REQ-024 Latency SHALL be: first byte_valid_out one cycle after word 7 is captured; 32 cycles to drain with ready held high.

Reset
REQ-025 While rst_n=0, the FSM SHALL be IDLE, the counters 0, and byte_out, byte_valid_out, digest_out, digest_done_out, busy_out and overrun_out all 0.
REQ-026 Reset mid-COLLECT or mid-SEND SHALL abandon the transfer; no partial digest_done_out SHALL occur.

Configuration
REQ-027 With macro DIGEST_COMPARE_EN defined, the block SHALL add input expected_digest_in[255:0] and output match_out; match_out SHALL be registered (digest_out == expected_digest_in) in DONE, held until the next capture in IDLE, and reset to 0.
REQ-028 Without DIGEST_COMPARE_EN, the ports and the comparator SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, DIGEST_WORDS=8, DIGEST_BYTES=32 and DIGEST_WIDTH=256.
REQ-030 The byte serializer (byte mux plus valid/ready counter) SHALL be a sub-module named digest_byte_mux.

Verification
REQ-031 Feed the 8 words of the "abc" digest (ba7816bf, 8f01cfea, 414140de, 5dae2223, b00361a3, 96177a9c, b410ff61, f20015ad) back-to-back with ready=1 -> digest_out matches, byte 0=0xBA, byte 31=0xAD, digest_done_out pulses 33 cycles after the last word.
REQ-032 Same words with gaps of 3 idle cycles between them -> identical digest_out and byte stream.
REQ-033 Ready toggled 1,0,0,1 during SEND -> byte_out is stable while stalled, no byte is skipped or duplicated, 32 bytes in total.
REQ-034 hash_valid_in pulsed at byte 10 of SEND -> overrun_out=1, byte stream unchanged, flag held after DONE.
REQ-035 clear_in after 4 words, then a full 8-word set -> only the new digest is output, one digest_done_out pulse.
REQ-036 With DIGEST_COMPARE_EN and expected set to the "abc" digest -> match_out=1; with bit 0 flipped -> match_out=0.
